pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_pkg.sv | 26 ++
 rtl/pong_score_bcd.sv | 34 +++
 rtl/pong_game_ctrl.sv | 155 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encodings, BCD score width, hold timing
// defaults and the score payload. Used by the controller, graphics and text stages.
package pong_pkg;

    localparam int unsigned BCD_W          = 8;
    localparam int unsigned STATE_W        = 2;
    localparam int unsigned HOLD_W         = 16;
    localparam int unsigned HOLD_TICKS_DEF = 120;

    localparam logic [BCD_W-1:0] WIN_SCORE_DEF = 8'h05;
    localparam logic [BCD_W-1:0] BCD_MAX       = 8'h99;

    typedef enum logic [STATE_W-1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } pong_state_e;

    // Two-digit BCD score for each player
    typedef struct packed {
        logic [BCD_W-1:0] left;
        logic [BCD_W-1:0] right;
    } score_pair_t;

endpackage

// File: rtl/pong_score_bcd.sv
// Two-digit BCD incrementer for one player's score; saturates at 99.
// Ports:
//   score_in    current BCD score
//   inc         request one increment
//   score_inc_c score_in + inc in BCD (combinational)
module pong_score_bcd
    import pong_pkg::*;
(
    input  logic [BCD_W-1:0] score_in,
    input  logic             inc,
    output logic [BCD_W-1:0] score_inc_c
);

    logic [3:0] lo_digit;
    logic [3:0] hi_digit;

    assign lo_digit = score_in[3:0];
    assign hi_digit = score_in[7:4];

    // Low digit wraps 9 -> 0 with carry; 99 holds rather than wrapping to 00
    always_comb begin
        score_inc_c = score_in;
        if (inc) begin
            if (score_in == BCD_MAX) begin
                score_inc_c = score_in;
            end else if (lo_digit >= 4'd9) begin
                score_inc_c = {4'(hi_digit + 4'd1), 4'd0};
            end else begin
                score_inc_c = {hi_digit, 4'(lo_digit + 4'd1)};
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: start, rally, point scoring, serve hold and
// game-over hold, with BCD scores per player.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   refresh_tick          one-cycle pulse per video frame (hold timebase)
//   missLeft, missRight   ball has passed the left / right edge (level)
//   btn_start             synchronised start button (level)
//   gra_still             freeze and recentre the ball
//   score_left/right      BCD scores
//   game_over, winner     OVER flag; winner 0 = left, 1 = right
//   state_o               current FSM state
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter logic [BCD_W-1:0] WIN_SCORE  = WIN_SCORE_DEF,
    parameter int unsigned      HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               refresh_tick,
    input  logic               missLeft,
    input  logic               missRight,
    input  logic               btn_start,
    output logic               gra_still,
    output logic [BCD_W-1:0]   score_left,
    output logic [BCD_W-1:0]   score_right,
    output logic               game_over,
    output logic               winner,
    output logic [STATE_W-1:0] state_o
);

    pong_state_e        state_q, state_d;
    score_pair_t        score_q, score_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               winner_q, winner_d;
    logic               gra_still_q, gra_still_d;
    logic               game_over_q, game_over_d;
    logic               btn_start_q;

    logic               start_edge;
    logic               left_scores;
    logic               right_scores;
    logic [BCD_W-1:0]   left_inc_c;
    logic [BCD_W-1:0]   right_inc_c;

    assign start_edge   = btn_start & ~btn_start_q;
    // A simultaneous miss on both sides is a dead ball: nobody scores
    assign left_scores  = missRight & ~missLeft;
    assign right_scores = missLeft & ~missRight;

    pong_score_bcd u_inc_left (
        .score_in    (score_q.left),
        .inc         (1'b1),
        .score_inc_c (left_inc_c)
    );

    pong_score_bcd u_inc_right (
        .score_in    (score_q.right),
        .inc         (1'b1),
        .score_inc_c (right_inc_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_NEWGAME;
            score_q     <= '0;
            hold_q      <= '0;
            winner_q    <= 1'b0;
            gra_still_q <= 1'b1;
            game_over_q <= 1'b0;
            btn_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            hold_q      <= hold_d;
            winner_q    <= winner_d;
            gra_still_q <= gra_still_d;
            game_over_q <= game_over_d;
            btn_start_q <= btn_start;
        end
    end

    // Next state, scoring and hold counter
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        winner_d = winner_q;
        hold_d   = hold_q;

        if (refresh_tick && (hold_q != '0)) begin
            hold_d = hold_q - HOLD_W'(1);
        end

        case (state_q)
            ST_NEWGAME: begin
                score_d  = '0;
                winner_d = 1'b0;
                if (start_edge) begin
                    state_d = ST_PLAY;
                end
            end

            // Leaving PLAY on the first miss cycle gives one point per miss event
            ST_PLAY: begin
                if (missLeft || missRight) begin
                    state_d = ST_NEWBALL;
                    hold_d  = HOLD_W'(HOLD_TICKS);
                    if (left_scores) begin
                        score_d.left = left_inc_c;
                        if (left_inc_c == WIN_SCORE) begin
                            state_d  = ST_OVER;
                            winner_d = 1'b0;
                        end
                    end else if (right_scores) begin
                        score_d.right = right_inc_c;
                        if (right_inc_c == WIN_SCORE) begin
                            state_d  = ST_OVER;
                            winner_d = 1'b1;
                        end
                    end
                end
            end

            ST_NEWBALL: begin
                if (hold_q == '0) begin
                    state_d = ST_PLAY;
                end
            end

            ST_OVER: begin
                if (start_edge && (hold_q == '0)) begin
                    state_d  = ST_NEWGAME;
                    score_d  = '0;
                    winner_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_NEWGAME;
            end
        endcase

        gra_still_d = (state_d != ST_PLAY);
        game_over_d = (state_d == ST_OVER);
    end

    assign gra_still   = gra_still_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign score_left  = score_q.left;
    assign score_right = score_q.right;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

    localparam logic [1:0] S_NEWGAME = 2'd0;
    localparam logic [1:0] S_PLAY    = 2'd1;
    localparam logic [1:0] S_NEWBALL = 2'd2;
    localparam logic [1:0] S_OVER    = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic       a_reset, a_tick, a_ml, a_mr, a_btn;
    logic       a_still, a_over, a_win;
    logic [7:0] a_l, a_r;
    logic [1:0] a_st;

    // Instance B: WIN_SCORE 99, short hold
    logic       b_reset, b_tick, b_ml, b_mr, b_btn;
    logic       b_still, b_over, b_win;
    logic [7:0] b_l, b_r;
    logic [1:0] b_st;

    pong_game_ctrl dut_a (
        .clk(clk), .reset(a_reset), .refresh_tick(a_tick),
        .missLeft(a_ml), .missRight(a_mr), .btn_start(a_btn),
        .gra_still(a_still), .score_left(a_l), .score_right(a_r),
        .game_over(a_over), .winner(a_win), .state_o(a_st)
    );

    pong_game_ctrl #(.WIN_SCORE(8'h99), .HOLD_TICKS(2)) dut_b (
        .clk(clk), .reset(b_reset), .refresh_tick(b_tick),
        .missLeft(b_ml), .missRight(b_mr), .btn_start(b_btn),
        .gra_still(b_still), .score_left(b_l), .score_right(b_r),
        .game_over(b_over), .winner(b_win), .state_o(b_st)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       still;
        logic       over;
        logic       win;
        logic [7:0] l;
        logic [7:0] r;
    } obs_t;

    typedef struct {
        string tag;
        bit    sel;
        obs_t  exp;
    } exp_t;

    exp_t sb[$];
    obs_t obs_a, obs_b;
    int   n_checks = 0;
    int   n_pass   = 0;

    assign obs_a = {a_st, a_still, a_over, a_win, a_l, a_r};
    assign obs_b = {b_st, b_still, b_over, b_win, b_l, b_r};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input bit sel, input logic [1:0] st,
                              input logic still, input logic over, input logic win,
                              input logic [7:0] l, input logic [7:0] r);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = {st, still, over, win, l, r};
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        obs_t o;
        e = sb.pop_front();
        o = e.sel ? obs_b : obs_a;
        n_checks++;
        assert (o === e.exp) n_pass++;
        else $error("FAIL %s: observed st=%0d still=%0b over=%0b win=%0b L=%h R=%h, expected st=%0d still=%0b over=%0b win=%0b L=%h R=%h",
                    e.tag, o.st, o.still, o.over, o.win, o.l, o.r,
                    e.exp.st, e.exp.still, e.exp.over, e.exp.win, e.exp.l, e.exp.r);
    endtask

    task automatic tick_a(input int n);
        repeat (n) begin
            a_tick = 1'b1;
            step();
            a_tick = 1'b0;
        end
    endtask

    task automatic tick_b(input int n);
        repeat (n) begin
            b_tick = 1'b1;
            step();
            b_tick = 1'b0;
        end
    endtask

    // Left player scores once on instance B, then serve hold runs out
    task automatic point_b();
        b_mr = 1'b1;
        step();
        b_mr = 1'b0;
        tick_b(2);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_reset = 1'b0; a_tick = 1'b0; a_ml = 1'b0; a_mr = 1'b0; a_btn = 1'b0;
        b_reset = 1'b0; b_tick = 1'b0; b_ml = 1'b0; b_mr = 1'b0; b_btn = 1'b0;
        step();
        step();

        expect_out("reset_a", 1'b0, S_NEWGAME, 1, 0, 0, 8'h00, 8'h00);
        compare();
        a_reset = 1'b1;
        step();

        // Start edge: PLAY one cycle later
        a_btn = 1'b1;
        expect_out("start", 1'b0, S_PLAY, 0, 0, 0, 8'h00, 8'h00);
        step();
        compare();
        a_btn = 1'b0;

        // Held missRight scores exactly once
        a_mr = 1'b1;
        expect_out("miss_right", 1'b0, S_NEWBALL, 1, 0, 0, 8'h01, 8'h00);
        step();
        compare();
        repeat (49) step();
        expect_out("miss_held", 1'b0, S_NEWBALL, 1, 0, 0, 8'h01, 8'h00);
        compare();
        a_mr = 1'b0;

        // Serve hold: still waiting after 119 ticks, back to PLAY after 120
        tick_a(119);
        expect_out("hold_119", 1'b0, S_NEWBALL, 1, 0, 0, 8'h01, 8'h00);
        compare();
        tick_a(1);
        expect_out("hold_done", 1'b0, S_PLAY, 0, 0, 0, 8'h01, 8'h00);
        step();
        compare();

        // Dead ball: both miss together
        a_ml = 1'b1;
        a_mr = 1'b1;
        expect_out("both_miss", 1'b0, S_NEWBALL, 1, 0, 0, 8'h01, 8'h00);
        step();
        compare();
        a_ml = 1'b0;
        a_mr = 1'b0;
        tick_a(120);
        step();

        // Right player to 4
        repeat (4) begin
            a_ml = 1'b1;
            step();
            a_ml = 1'b0;
            tick_a(120);
            step();
        end
        expect_out("right_4", 1'b0, S_PLAY, 0, 0, 0, 8'h01, 8'h04);
        compare();

        // Winning point goes straight to OVER
        a_ml = 1'b1;
        expect_out("win_right", 1'b0, S_OVER, 1, 1, 1, 8'h01, 8'h05);
        step();
        compare();
        a_ml = 1'b0;
        step();

        a_btn = 1'b1;
        expect_out("over_btn_early", 1'b0, S_OVER, 1, 1, 1, 8'h01, 8'h05);
        step();
        compare();
        a_btn = 1'b0;
        step();

        a_ml = 1'b1;
        expect_out("over_frozen", 1'b0, S_OVER, 1, 1, 1, 8'h01, 8'h05);
        step();
        compare();
        a_ml = 1'b0;

        tick_a(119);
        a_btn = 1'b1;
        expect_out("over_btn_119", 1'b0, S_OVER, 1, 1, 1, 8'h01, 8'h05);
        step();
        compare();
        a_btn = 1'b0;
        step();

        tick_a(1);
        a_btn = 1'b1;
        expect_out("over_to_newgame", 1'b0, S_NEWGAME, 1, 0, 0, 8'h00, 8'h00);
        step();
        compare();
        a_btn = 1'b0;
        step();

        // Async reset mid-hold
        a_btn = 1'b1;
        step();
        a_btn = 1'b0;
        a_mr = 1'b1;
        step();
        a_mr = 1'b0;
        tick_a(60);
        #2;
        a_reset = 1'b0;
        #1;
        expect_out("async_reset", 1'b0, S_NEWGAME, 1, 0, 0, 8'h00, 8'h00);
        compare();
        step();
        a_reset = 1'b1;
        step();

        a_btn = 1'b1;
        expect_out("restart", 1'b0, S_PLAY, 0, 0, 0, 8'h00, 8'h00);
        step();
        compare();
        a_btn = 1'b0;

        // Instance B: BCD carry and saturation
        expect_out("reset_b", 1'b1, S_NEWGAME, 1, 0, 0, 8'h00, 8'h00);
        compare();
        b_reset = 1'b1;
        step();
        b_btn = 1'b1;
        step();
        b_btn = 1'b0;

        repeat (9) point_b();
        expect_out("left_09", 1'b1, S_PLAY, 0, 0, 0, 8'h09, 8'h00);
        compare();
        point_b();
        expect_out("left_10", 1'b1, S_PLAY, 0, 0, 0, 8'h10, 8'h00);
        compare();
        repeat (89) point_b();
        expect_out("left_99", 1'b1, S_OVER, 1, 1, 0, 8'h99, 8'h00);
        compare();
        point_b();
        expect_out("left_sat", 1'b1, S_OVER, 1, 1, 0, 8'h99, 8'h00);
        compare();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
